// File: rtl/shift_add_multiplier_pkg.sv
// rtl/shift_add_multiplier_pkg.sv - shared operand width and FSM state type for the multiplier
package Parameter_Definitions;

  // Default operand width of the multiplier datapath
  localparam int NBits = 8;

  // Multiplier sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_bit_counter.sv
// rtl/shift_add_multiplier_bit_counter.sv - up counter with synchronous clear and count enable
module bit_counter #(
  parameter int Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [Width-1:0] count
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;

  // Clear has priority over enable so a new operation always starts from zero
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + One;
    end
  end

  // Count register, asynchronously cleared by the active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential sign-magnitude shift-and-add multiplier
module shift_add_multiplier #(
  parameter int NBits = Parameter_Definitions::NBits
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Start,
  input  logic [NBits-1:0]     Multiplicand,
  input  logic [NBits-1:0]     Multiplier,
  output logic [2*NBits-1:0]   Reg_Part1,
  output logic                 Sign,
  output logic                 Ready,
  output logic                 Busy
);

  import Parameter_Definitions::*;

  localparam int CntW = $clog2(NBits) + 1;
  localparam int PW   = 2 * NBits;
  localparam logic [NBits-1:0] OneN    = NBits'(1);
  localparam logic [CntW-1:0]  LastCnt = CntW'(NBits - 1);

  state_t state_q, state_d;

  logic [NBits-1:0] a_q, a_d;
  logic [NBits-1:0] b_q, b_d;
  logic [NBits-1:0] mcand_q, mcand_d;
  logic [NBits-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    reg_part1_q, reg_part1_d;
  logic             sign_q, sign_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic [CntW-1:0]  cnt;
  logic             cnt_clear;
  logic             cnt_en;

  logic [NBits-1:0] a_mag;
  logic [NBits-1:0] b_mag;
  logic [PW-1:0]    partial;

  // Magnitudes of the captured operands; the most-negative value maps to 2^(NBits-1),
  // which still fits in NBits unsigned bits
  always_comb begin
    a_mag   = a_q[NBits-1] ? (~a_q + OneN) : a_q;
    b_mag   = b_q[NBits-1] ? (~b_q + OneN) : b_q;
    partial = {{NBits{1'b0}}, mcand_q} << cnt;
  end

  bit_counter #(
    .Width (CntW)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (cnt)
  );

  // Next-state and datapath update; Start is only looked at in IDLE so requests
  // during an operation or in DONE are dropped
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    reg_part1_d = reg_part1_q;
    sign_d      = sign_q;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = Multiplicand;
          b_d     = Multiplier;
          state_d = LOAD;
        end
      end

      LOAD: begin
        mcand_d   = a_mag;
        mplier_d  = b_mag;
        acc_d     = '0;
        cnt_clear = 1'b1;
        if ((a_q != '0) && (b_q != '0)) begin
          sign_d = a_q[NBits-1] ^ b_q[NBits-1];
        end else begin
          sign_d = 1'b0;
        end
        state_d = SHIFT;
      end

      SHIFT: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + partial;
        end
        mplier_d = mplier_q >> 1;
        cnt_en   = 1'b1;
        if (cnt == LastCnt) begin
          reg_part1_d = acc_d;
          state_d     = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == DONE);
    busy_d  = (state_d == LOAD) || (state_d == SHIFT);
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      reg_part1_q <= '0;
      sign_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      reg_part1_q <= reg_part1_d;
      sign_q      <= sign_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign Reg_Part1 = reg_part1_q;
  assign Sign      = sign_q;
  assign Ready     = ready_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [7:0]  Multiplicand;
  logic [7:0]  Multiplier;
  logic [15:0] Reg_Part1;
  logic        Sign;
  logic        Ready;
  logic        Busy;

  int n_checks;
  int n_fail;

  shift_add_multiplier #(
    .NBits (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Start        (Start),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Reg_Part1    (Reg_Part1),
    .Sign         (Sign),
    .Ready        (Ready),
    .Busy         (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start is sampled on edge 0; Ready must appear 9 edges later (cycle 10)
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         input int exp_mag, input logic exp_sign);
    int lat;
    lat = 0;
    Multiplicand = a;
    Multiplier   = b;
    Start        = 1'b1;
    @(posedge clk); #1;
    Start        = 1'b0;
    Multiplicand = ~a;
    Multiplier   = b + 8'd37;
    chk("busy_in_load", Busy, 1);
    while (!Ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 9);
    chk("product", Reg_Part1, exp_mag);
    chk("sign", Sign, exp_sign);
    @(posedge clk); #1;
    chk("ready_pulse", Ready, 0);
    chk("product_hold", Reg_Part1, exp_mag);
    chk("busy_after", Busy, 0);
  endtask

  initial begin
    int rcount;
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b0;
    Start        = 1'b0;
    Multiplicand = '0;
    Multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_product", Reg_Part1, 0);
    chk("rst_sign", Sign, 0);
    chk("rst_ready", Ready, 0);
    chk("rst_busy", Busy, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    run_mul(8'd3,   8'd5,   15,    1'b0);
    run_mul(8'hFD,  8'd5,   15,    1'b1);
    run_mul(8'hF9,  8'hFA,  42,    1'b0);
    run_mul(8'h80,  8'h80,  16384, 1'b0);
    run_mul(8'h80,  8'h7F,  16256, 1'b1);
    run_mul(8'd0,   8'hF9,  0,     1'b0);
    run_mul(8'd5,   8'd0,   0,     1'b0);
    run_mul(8'hFF,  8'hFF,  1,     1'b0);

    // Start re-pulsed on edges 3 (SHIFT) and 10 (DONE) must be ignored
    Multiplicand = 8'd9;
    Multiplier   = 8'hF5;
    Start        = 1'b1;
    @(posedge clk); #1;
    Start  = 1'b0;
    rcount = 0;
    for (int e = 1; e <= 20; e++) begin
      Start = (e == 3) || (e == 10);
      @(posedge clk); #1;
      if (Ready) rcount++;
      if (e == 9) begin
        chk("repulse_product", Reg_Part1, 99);
        chk("repulse_sign", Sign, 1);
      end
    end
    Start = 1'b0;
    chk("repulse_one_ready", rcount, 1);
    chk("repulse_idle", Busy, 0);

    // Reset during SHIFT aborts the operation
    Multiplicand = 8'd11;
    Multiplier   = 8'd13;
    Start        = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_product", Reg_Part1, 0);
    chk("abort_sign", Sign, 0);
    chk("abort_ready", Ready, 0);
    chk("abort_busy", Busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b1;
    rcount = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (Ready) rcount++;
    end
    chk("abort_no_ready", rcount, 0);

    run_mul(8'hF9, 8'd6, 42, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
